mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch, data), the shared memory and the arbiter.
// The arbiter attaches through the slave modport; the environment drives through master.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  // Instruction-fetch side
  logic              IF_Req;
  logic [ADDR_W-1:0] IF_Addr;
  logic              IF_Grant;
  logic              IF_Valid;
  logic [DATA_W-1:0] IF_RData;
  // Data-memory side
  logic              DM_Req;
  logic              DM_Write;
  logic [ADDR_W-1:0] DM_Addr;
  logic [DATA_W-1:0] DM_WData;
  logic [1:0]        DM_ByteSel;
  logic              DM_Grant;
  logic              DM_Valid;
  logic [DATA_W-1:0] DM_RData;
  // Shared memory side
  logic              Mem_Req;
  logic              Mem_Write;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_WData;
  logic [1:0]        Mem_ByteSel;
  logic              Mem_Ready;
  logic [DATA_W-1:0] Mem_RData;
  // Pipeline freeze
  logic              Stall;

  modport slave (
    input  IF_Req, IF_Addr,
    input  DM_Req, DM_Write, DM_Addr, DM_WData, DM_ByteSel,
    input  Mem_Ready, Mem_RData,
    output IF_Grant, IF_Valid, IF_RData,
    output DM_Grant, DM_Valid, DM_RData,
    output Mem_Req, Mem_Write, Mem_Addr, Mem_WData, Mem_ByteSel,
    output Stall
  );

  modport master (
    output IF_Req, IF_Addr,
    output DM_Req, DM_Write, DM_Addr, DM_WData, DM_ByteSel,
    output Mem_Ready, Mem_RData,
    input  IF_Grant, IF_Valid, IF_RData,
    input  DM_Grant, DM_Valid, DM_RData,
    input  Mem_Req, Mem_Write, Mem_Addr, Mem_WData, Mem_ByteSel,
    input  Stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data access.
// Data wins by default; fetch wins once it has lost MAX_FETCH_WAIT grants in a row.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_FETCH_WAIT = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned     CntW   = $clog2(MAX_FETCH_WAIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_FETCH_WAIT);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              if_grant_q, if_grant_d;
  logic              dm_grant_q, dm_grant_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_bytesel_q, mem_bytesel_d;
  logic              if_wins;

  // Fetch overrides data only when it is starved and still asking.
  assign if_wins = bus.IF_Req && (!bus.DM_Req || (cnt_q == CntMax));

  // Next-state: arbitrate in idle, wait for memory completion in busy.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    if_grant_d    = 1'b0;
    dm_grant_d    = 1'b0;
    if_valid_d    = 1'b0;
    dm_valid_d    = 1'b0;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_bytesel_d = mem_bytesel_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.IF_Req) cnt_d = '0;
        if (if_wins) begin
          state_d       = StBusyIf;
          if_grant_d    = 1'b1;
          cnt_d         = '0;
          mem_write_d   = 1'b0;
          mem_addr_d    = bus.IF_Addr;
          mem_wdata_d   = '0;
          mem_bytesel_d = 2'b00;
        end else if (bus.DM_Req) begin
          state_d       = StBusyDm;
          dm_grant_d    = 1'b1;
          if (bus.IF_Req && (cnt_q != CntMax)) cnt_d = cnt_q + CntW'(1);
          mem_write_d   = bus.DM_Write;
          mem_addr_d    = bus.DM_Addr;
          mem_wdata_d   = bus.DM_WData;
          mem_bytesel_d = bus.DM_ByteSel;
        end
      end
      StBusyIf: begin
        if (bus.Mem_Ready) begin
          state_d    = StIdle;
          if_valid_d = 1'b1;
          if_rdata_d = bus.Mem_RData;
        end
      end
      StBusyDm: begin
        if (bus.Mem_Ready) begin
          state_d    = StIdle;
          dm_valid_d = 1'b1;
          // Stores complete without disturbing the last load value.
          if (!mem_write_q) dm_rdata_d = bus.Mem_RData;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      if_grant_q    <= 1'b0;
      dm_grant_q    <= 1'b0;
      if_valid_q    <= 1'b0;
      dm_valid_q    <= 1'b0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_bytesel_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      if_grant_q    <= if_grant_d;
      dm_grant_q    <= dm_grant_d;
      if_valid_q    <= if_valid_d;
      dm_valid_q    <= dm_valid_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_bytesel_q <= mem_bytesel_d;
    end
  end

  assign bus.IF_Grant    = if_grant_q;
  assign bus.IF_Valid    = if_valid_q;
  assign bus.IF_RData    = if_rdata_q;
  assign bus.DM_Grant    = dm_grant_q;
  assign bus.DM_Valid    = dm_valid_q;
  assign bus.DM_RData    = dm_rdata_q;
  // Decoded from state so reset drops the request without waiting for a clock.
  assign bus.Mem_Req     = (state_q != StIdle);
  assign bus.Mem_Write   = mem_write_q;
  assign bus.Mem_Addr    = mem_addr_q;
  assign bus.Mem_WData   = mem_wdata_q;
  assign bus.Mem_ByteSel = mem_bytesel_q;
  assign bus.Stall       = (bus.IF_Req & ~if_valid_q) | (bus.DM_Req & ~dm_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, starvation, zero-wait, reset abort.
module tb_mem_port_arbiter;

  logic Clock;
  logic Reset;
  int   n_vec;
  int   n_err;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .MAX_FETCH_WAIT(4)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the rising edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset              = 1'b0;
    bus.IF_Req         = 1'b0;
    bus.IF_Addr        = '0;
    bus.DM_Req         = 1'b0;
    bus.DM_Write       = 1'b0;
    bus.DM_Addr        = '0;
    bus.DM_WData       = '0;
    bus.DM_ByteSel     = 2'b00;
    bus.Mem_Ready      = 1'b0;
    bus.Mem_RData      = '0;

    // Reset state
    #2;
    chk("rst_mem_req", bus.Mem_Req, 0);
    chk("rst_mem_addr", bus.Mem_Addr, 0);
    chk("rst_if_rdata", bus.IF_RData, 0);
    chk("rst_stall", bus.Stall, 0);
    step();
    Reset = 1'b1;

    // Single fetch with memory ready on the third busy cycle
    bus.IF_Req    = 1'b1;
    bus.IF_Addr   = 32'h40;
    bus.Mem_RData = 32'h8C020004;
    #1;
    chk("f_stall_pre", bus.Stall, 1);
    step();
    chk("f_if_grant", bus.IF_Grant, 1);
    chk("f_mem_req0", bus.Mem_Req, 1);
    chk("f_mem_addr0", bus.Mem_Addr, 32'h40);
    chk("f_mem_write", bus.Mem_Write, 0);
    step();
    chk("f_if_grant_drop", bus.IF_Grant, 0);
    chk("f_mem_addr1", bus.Mem_Addr, 32'h40);
    step();
    chk("f_mem_req2", bus.Mem_Req, 1);
    chk("f_mem_addr2", bus.Mem_Addr, 32'h40);
    chk("f_no_early_valid", bus.IF_Valid, 0);
    bus.Mem_Ready = 1'b1;
    step();
    chk("f_if_valid", bus.IF_Valid, 1);
    chk("f_if_rdata", bus.IF_RData, 32'h8C020004);
    chk("f_mem_req_drop", bus.Mem_Req, 0);
    chk("f_stall_valid", bus.Stall, 0);
    bus.Mem_Ready = 1'b0;
    bus.IF_Req    = 1'b0;
    step();
    chk("f_if_valid_pulse", bus.IF_Valid, 0);
    chk("f_if_rdata_hold", bus.IF_RData, 32'h8C020004);
    chk("f_idle_no_grant", bus.IF_Grant, 0);

    // Simultaneous requests, zero-wait memory: data write wins first
    bus.IF_Req     = 1'b1;
    bus.IF_Addr    = 32'h44;
    bus.DM_Req     = 1'b1;
    bus.DM_Write   = 1'b1;
    bus.DM_Addr    = 32'h100;
    bus.DM_WData   = 32'hDEADBEEF;
    bus.DM_ByteSel = 2'b10;
    bus.Mem_Ready  = 1'b1;
    step();
    chk("s_dm_grant", bus.DM_Grant, 1);
    chk("s_if_lost", bus.IF_Grant, 0);
    chk("s_mem_write", bus.Mem_Write, 1);
    chk("s_mem_addr", bus.Mem_Addr, 32'h100);
    chk("s_mem_wdata", bus.Mem_WData, 32'hDEADBEEF);
    chk("s_mem_bytesel", bus.Mem_ByteSel, 2'b10);
    bus.DM_Req    = 1'b0;
    bus.Mem_RData = 32'h11111111;
    step();
    chk("s_dm_valid", bus.DM_Valid, 1);
    chk("s_dm_rdata_hold", bus.DM_RData, 0);
    chk("s_no_arb_valid_edge", bus.IF_Grant, 0);
    chk("s_stall_if", bus.Stall, 1);
    step();
    chk("s_if_grant", bus.IF_Grant, 1);
    chk("s_if_addr", bus.Mem_Addr, 32'h44);
    chk("s_if_write0", bus.Mem_Write, 0);
    chk("s_if_bytesel0", bus.Mem_ByteSel, 2'b00);
    chk("s_dm_valid_pulse", bus.DM_Valid, 0);
    bus.IF_Req = 1'b0;
    step();
    chk("s_if_valid", bus.IF_Valid, 1);
    chk("s_if_rdata", bus.IF_RData, 32'h11111111);
    bus.Mem_Ready = 1'b0;
    step();

    // Starvation: four data reads, then a forced fetch; twice to show the count restarts
    bus.IF_Req     = 1'b1;
    bus.IF_Addr    = 32'h80;
    bus.DM_Req     = 1'b1;
    bus.DM_Write   = 1'b0;
    bus.DM_Addr    = 32'h200;
    bus.DM_ByteSel = 2'b01;
    bus.Mem_Ready  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        bus.Mem_RData = 32'hA5A50000 + 32'(r * 16 + k);
        step();
        chk("st_dm_grant", bus.DM_Grant, 1);
        chk("st_if_wait", bus.IF_Grant, 0);
        step();
        chk("st_dm_valid", bus.DM_Valid, 1);
        chk("st_dm_rdata", bus.DM_RData, 32'hA5A50000 + 32'(r * 16 + k));
      end
      bus.Mem_RData = 32'h12345678 + 32'(r);
      step();
      chk("st_if_grant", bus.IF_Grant, 1);
      chk("st_dm_blocked", bus.DM_Grant, 0);
      chk("st_if_addr", bus.Mem_Addr, 32'h80);
      step();
      chk("st_if_valid", bus.IF_Valid, 1);
      chk("st_if_rdata", bus.IF_RData, 32'h12345678 + 32'(r));
    end
    bus.IF_Req    = 1'b0;
    bus.DM_Req    = 1'b0;
    bus.Mem_Ready = 1'b0;
    step();

    // Request withdrawn before an edge, and Mem_Ready in idle, are both ignored
    bus.Mem_Ready = 1'b1;
    bus.DM_Req    = 1'b1;
    #2;
    bus.DM_Req = 1'b0;
    step();
    chk("i_no_grant", bus.DM_Grant, 0);
    chk("i_no_mem_req", bus.Mem_Req, 0);
    step();
    chk("i_no_valid", bus.DM_Valid, 0);
    bus.Mem_Ready = 1'b0;

    // Reset during a data read abandons it; pending fetch wins on the first edge after
    bus.DM_Req  = 1'b1;
    bus.DM_Addr = 32'h300;
    step();
    chk("r_dm_grant", bus.DM_Grant, 1);
    chk("r_mem_req", bus.Mem_Req, 1);
    bus.DM_Req  = 1'b0;
    bus.IF_Req  = 1'b1;
    bus.IF_Addr = 32'h48;
    step();
    chk("r_busy_hold", bus.Mem_Req, 1);
    #2;
    Reset = 1'b0;
    #1;
    chk("r_mem_req_async", bus.Mem_Req, 0);
    chk("r_mem_addr_clr", bus.Mem_Addr, 0);
    chk("r_dm_rdata_clr", bus.DM_RData, 0);
    bus.Mem_Ready = 1'b1;
    step();
    chk("r_no_dm_valid", bus.DM_Valid, 0);
    Reset = 1'b1;
    step();
    chk("r_if_grant", bus.IF_Grant, 1);
    chk("r_if_addr", bus.Mem_Addr, 32'h48);
    chk("r_no_dm_valid2", bus.DM_Valid, 0);
    bus.IF_Req = 1'b0;
    step();
    chk("r_if_valid", bus.IF_Valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
